logic16_arbiter: RTL and testbench

- Shares one 16-bit bitwise logic unit (NOT/AND/OR/XOR) among N_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Each operation is sequenced through a 3-state FSM. The result is returned to the granted requester with a one-cycle done pulse.
- Sits between client blocks and the shared bitwise datapath, so that only one instance of the 16-bit gate array is needed.

---
 rtl/logic16_arbiter.sv | 133 +++++++++++++
 tb/tb_logic16_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic16_arbiter.sv
// logic16_arbiter: round-robin access to one shared 16-bit bitwise logic unit
// (NOT/AND/OR/XOR). One operation in flight at a time, sequenced IDLE -> EXEC
// -> DONE, so the peak rate is one operation every three cycles.
//
// Handshake: a requester raises req[i] with its op/a/b slices stable and keeps
// them stable until it sees gnt[i] (a one-cycle pulse meaning "operands
// latched"). It may drop req[i] in the gnt cycle; if req[i] is still high at
// the next IDLE cycle it is a new request. done[i] pulses exactly one cycle
// after gnt[i], with result valid in that cycle and held until the next
// completion. The FSM state is observable through the 'state' signal.
module logic16_arbiter #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       op,
  input  logic [WIDTH*N_REQ-1:0]   a,
  input  logic [WIDTH*N_REQ-1:0]   b,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [WIDTH-1:0]         result,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]    ptr;        // search starts here
  logic [IW-1:0]    cur_idx;    // requester owning the in-flight operation
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    cand;
  logic             pick_found;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] lu_out;

  // Round-robin pick: first set req bit scanning upward from ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Shared bitwise unit, purely combinational on the latched operands.
  always_comb begin
    lu_out = '0;
    case (op_q)
      2'b00:   lu_out = ~a_q;
      2'b01:   lu_out = a_q & b_q;
      2'b10:   lu_out = a_q | b_q;
      default: lu_out = a_q ^ b_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: leave IDLE only when something was picked; EXEC and DONE are one cycle each.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_found) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, operand capture, pointer and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= '0;
      done     <= '0;
      result   <= '0;
      busy     <= 1'b0;
      op_count <= '0;
      ptr      <= '0;
      cur_idx  <= '0;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            cur_idx <= pick_idx;
            op_q    <= op[2*int'(pick_idx) +: 2];
            a_q     <= a[WIDTH*int'(pick_idx) +: WIDTH];
            b_q     <= b[WIDTH*int'(pick_idx) +: WIDTH];
            gnt     <= ONE << pick_idx;
            busy    <= 1'b1;
          end
        end
        ST_EXEC: begin
          result   <= lu_out;
          done     <= ONE << cur_idx;
          op_count <= op_count + 1'b1;
          ptr      <= (cur_idx == IW'(N_REQ-1)) ? '0 : cur_idx + 1'b1;
        end
        ST_DONE: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Testbench for logic16_arbiter: directed scenarios plus random request
// batches. A driver predicts each winner and expected response from a
// behavioural model and queues it; a monitor pops and compares on every done.
module tb_logic16_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int EW = N + W + CW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] op = '0;
  logic [W*N-1:0] a = '0;
  logic [W*N-1:0] b = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;
  logic [CW-1:0]  op_count;

  logic [EW-1:0]  exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_gnt_cyc = -10;
  int model_ptr = 0;
  int model_cnt = 0;

  logic16_arbiter #(.WIDTH(W), .N_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .op_count(op_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_lu(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      2'b00:   return ~x;
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick_winner(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
    op[2*i +: 2] = o;
    a[W*i +: W]  = x;
    b[W*i +: W]  = y;
    req[i]       = 1'b1;
  endtask

  task automatic set_req_rand(input int i);
    set_req(i, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
  endtask

  task automatic push_exp(input int w);
    logic [W-1:0] res;
    res = ref_lu(op[2*w +: 2], a[W*w +: W], b[W*w +: W]);
    model_cnt = (model_cnt + 1) % (1 << CW);
    exp_q.push_back({onehot(w), res, CW'(model_cnt)});
  endtask

  // Wait (bounded) for a grant and compare it with the predicted winner.
  task automatic wait_gnt(input int w);
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    check("gnt", 32'(gnt), 32'(onehot(w)));
    model_ptr = (w + 1) % N;
  endtask

  // Serve every currently raised request; each requester drops req on its grant.
  task automatic serve_batch();
    int w;
    while (req != '0) begin
      w = pick_winner(req);
      push_exp(w);
      wait_gnt(w);
      req[w] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    rst_n = 1'b1;
    model_ptr = 0;
    model_cnt = 0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (gnt != '0 || done != '0)
        check("gnt_done_exclusive", 32'(gnt & done), 32'h0);
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("done", 32'(done), 32'(e[EW-1 -: N]));
          check("result", 32'(result), 32'(e[W+CW-1 -: W]));
          check("op_count", 32'(op_count), 32'(e[CW-1:0]));
          check("done_latency", cyc - last_gnt_cyc, 1);
          check("busy_at_done", 32'(busy), 32'h1);
        end
      end
      if (gnt != '0) last_gnt_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   t2_op[4];
    logic [W-1:0] t2_res[4];
    int prev;
    int w;
    t2_op  = '{2'b01, 2'b10, 2'b11, 2'b00};
    t2_res = '{16'h1000, 16'h3EF7, 16'h2EF7, 16'hC33C};

    repeat (3) @(negedge clk);
    apply_reset();

    // single requester 0, NOT 0xAAAA
    set_req(0, 2'b00, 16'hAAAA, 16'h0000);
    serve_batch();
    @(negedge clk);
    check("t1_result", 32'(result), 32'h5555);
    check("t1_count", 32'(op_count), 32'h1);
    @(negedge clk);
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_result_held", 32'(result), 32'h5555);

    // requester 2, each opcode
    for (int k = 0; k < 4; k++) begin
      set_req(2, t2_op[k], 16'h3CC3, 16'h1234);
      serve_batch();
      @(negedge clk);
      check("t2_result", 32'(result), 32'(t2_res[k]));
    end
    repeat (2) @(negedge clk);

    // all requesters continuously active: strict rotation at 3-cycle spacing
    apply_reset();
    for (int i = 0; i < N; i++) set_req_rand(i);
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      w = pick_winner(req);
      push_exp(w);
      wait_gnt(w);
      check("rr_order", 32'(gnt), 32'(onehot(k % N)));
      if (k > 0) check("rr_spacing", cyc - prev, 3);
      prev = cyc;
    end
    req = '0;
    repeat (3) @(negedge clk);

    // operand change after grant must not affect the result
    set_req(0, 2'b00, 16'h0000, 16'h0000);
    w = pick_winner(req);
    push_exp(w);
    wait_gnt(w);
    a[0 +: W] = 16'hFFFF;
    req[0] = 1'b0;
    @(negedge clk);
    check("stable_result", 32'(result), 32'hFFFF);
    repeat (2) @(negedge clk);

    // reset during EXEC: in-flight op discarded, pointer back to 0
    set_req_rand(2);
    serve_batch();
    repeat (2) @(negedge clk);
    set_req_rand(3);
    w = pick_winner(req);
    push_exp(w);
    wait_gnt(w);
    rst_n = 1'b0;
    req = '0;
    exp_q.delete();
    @(negedge clk);
    check("exec_rst_done", 32'(done), 32'h0);
    check("exec_rst_result", 32'(result), 32'h0);
    check("exec_rst_count", 32'(op_count), 32'h0);
    check("exec_rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    model_ptr = 0;
    model_cnt = 0;
    for (int i = 0; i < N; i++) set_req_rand(i);
    push_exp(0);
    wait_gnt(0);
    check("ptr_after_reset", 32'(gnt), 32'h1);
    req = '0;
    repeat (3) @(negedge clk);

    // counter wrap with CW=4: 17 completions read back as 1
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      set_req_rand($urandom_range(0, N-1));
      serve_batch();
      repeat (2) @(negedge clk);
    end
    check("wrap_count", 32'(op_count), 32'h1);

    // random request batches
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1) set_req_rand(i);
      if (req == '0) set_req_rand($urandom_range(0, N-1));
      serve_batch();
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
